ram_port_arbiter: RTL and testbench

//  Shares the single-port synchronous data RAM between two requesters: port 0 = CPU load/store

---
 rtl/ram_port_arbiter_pkg.sv | 16 +
 rtl/ram_port_arbiter_starve.sv | 34 +++
 rtl/ram_port_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and default sizes for the two-port RAM arbiter.
// Owner state records which requester a just-issued read belongs to.
package ram_port_arbiter_pkg;

  localparam int ADDR_W_DEF   = 9;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam int WAIT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2
  } owner_state_e;

endpackage

// File: rtl/ram_port_arbiter_starve.sv
// Saturating count of consecutive cycles the I/O port was refused;
// raises force1 once the port has waited MAX_WAIT cycles.
module arb_starve_counter
  import ram_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_req,
  input  logic m1_gnt,
  output logic force1
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_r;

  // Wait counter: clears when port 1 is served or stops asking, else saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (!m1_req || m1_gnt) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (wait_cnt_r != MAX_WAIT_C) begin
      wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign force1 = m1_req && (wait_cnt_r == MAX_WAIT_C);

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the CPU (port 0, priority)
// and the I/O engine (port 1), routing each read result back to its issuer.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  owner_state_e state_r;
  owner_state_e state_nxt_s;
  logic         force1_s;
  logic         m0_gnt_s;
  logic         m1_gnt_s;

  arb_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .m1_req (m1_req),
    .m1_gnt (m1_gnt_s),
    .force1 (force1_s)
  );

  // Grants are suppressed during reset so no access can slip through.
  assign m1_gnt_s = !rst && m1_req && (!m0_req || force1_s);
  assign m0_gnt_s = !rst && m0_req && !m1_gnt_s;
  assign m0_gnt   = m0_gnt_s;
  assign m1_gnt   = m1_gnt_s;

  // RAM request mux: drive the granted port's access, all zero when idle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = {DATA_W{1'b0}};
    if (m1_gnt_s) begin
      ram_en    = 1'b1;
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end else if (m0_gnt_s) begin
      ram_en    = 1'b1;
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else begin
      ram_en    = 1'b0;
    end
  end

  // Owner state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next owner: only reads are tracked, since writes return nothing.
  always_comb begin
    state_nxt_s = ST_IDLE;
    if (m0_gnt_s && !m0_we) begin
      state_nxt_s = ST_RD0;
    end else if (m1_gnt_s && !m1_we) begin
      state_nxt_s = ST_RD1;
    end else begin
      state_nxt_s = ST_IDLE;
    end
  end

  // Read return steering; a reset in the return cycle drops the pending data.
  always_comb begin
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = {DATA_W{1'b0}};
    m1_rdata  = {DATA_W{1'b0}};
    case (state_r)
      ST_RD0: begin
        if (!rst) begin
          m0_rvalid = 1'b1;
          m0_rdata  = ram_rdata;
        end else begin
          m0_rvalid = 1'b0;
        end
      end
      ST_RD1: begin
        if (!rst) begin
          m1_rvalid = 1'b1;
          m1_rdata  = ram_rdata;
        end else begin
          m1_rvalid = 1'b0;
        end
      end
      default: begin
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Table-driven bench for ram_port_arbiter with a behavioural RAM and a
// read-return scoreboard fed from a shadow copy of memory.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [8:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_we;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  logic [31:0] mem    [512];
  logic [31:0] shadow [512];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        r0, we0;
    logic [8:0]  a0;
    logic [31:0] d0;
    logic        r1, we1;
    logic [8:0]  a1;
    logic [31:0] d1;
    logic        g0, g1;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rd_exp_t;

  vec_t    tbl[$];
  rd_exp_t sb[$];

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port synchronous RAM.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  function automatic vec_t mkv(logic r, logic q0, logic w0, logic [8:0] a0, logic [31:0] d0,
                               logic q1, logic w1, logic [8:0] a1, logic [31:0] d1,
                               logic g0, logic g1);
    vec_t v;
    v.rst = r;  v.r0 = q0; v.we0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = q1;  v.we1 = w1; v.a1 = a1; v.d1 = d1; v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check mid-cycle, update the reference model.
  task automatic apply(input vec_t v, input string tag);
    rd_exp_t     e;
    logic        rv0, rv1, ew, en;
    logic [8:0]  ea;
    logic [31:0] rd0, rd1, ed;
    rst = v.rst;
    m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
    #4;
    rv0 = 1'b0; rv1 = 1'b0; rd0 = 32'h0; rd1 = 32'h0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!v.rst) begin
        if (e.port) begin rv1 = 1'b1; rd1 = e.data; end
        else        begin rv0 = 1'b1; rd0 = e.data; end
      end
    end
    en = v.g0 | v.g1;
    ew = v.g1 ? v.we1 : (v.g0 ? v.we0 : 1'b0);
    ea = v.g1 ? v.a1  : (v.g0 ? v.a0  : 9'h0);
    ed = v.g1 ? v.d1  : (v.g0 ? v.d0  : 32'h0);
    chk({tag, " m0_gnt"},    {31'h0, m0_gnt},    {31'h0, v.g0});
    chk({tag, " m1_gnt"},    {31'h0, m1_gnt},    {31'h0, v.g1});
    chk({tag, " ram_en"},    {31'h0, ram_en},    {31'h0, en});
    chk({tag, " ram_we"},    {31'h0, ram_we},    {31'h0, ew});
    chk({tag, " ram_addr"},  {23'h0, ram_addr},  {23'h0, ea});
    chk({tag, " ram_wdata"}, ram_wdata,          ed);
    chk({tag, " m0_rvalid"}, {31'h0, m0_rvalid}, {31'h0, rv0});
    chk({tag, " m0_rdata"},  m0_rdata,           rd0);
    chk({tag, " m1_rvalid"}, {31'h0, m1_rvalid}, {31'h0, rv1});
    chk({tag, " m1_rdata"},  m1_rdata,           rd1);
    if (v.g0) begin
      if (v.we0) shadow[v.a0] = v.d0;
      else       sb.push_back('{1'b0, shadow[v.a0]});
    end
    if (v.g1) begin
      if (v.we1) shadow[v.a1] = v.d1;
      else       sb.push_back('{1'b1, shadow[v.a1]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 512; i++) begin
      mem[i]    = 32'hA500_0000 | 32'(i);
      shadow[i] = 32'hA500_0000 | 32'(i);
    end
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 9'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 9'h0; m1_wdata = 32'h0;
    @(posedge clk);
    #1;

    // Reset with both ports requesting.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mkv(1'b1, 1'b1, 1'b0, 9'h010, 32'h0, 1'b1, 1'b0, 9'h020, 32'h0, 1'b0, 1'b0));
    // CPU write then read back.
    tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0));
    // Back-to-back reads, m0 then m1.
    tbl.push_back(mkv(1'b0, 1'b1, 1'b0, 9'h001, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h002, 32'h0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0));
    // Reset the cycle after an m1 read grant.
    tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h007, 32'h0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0));
    // m1 drops request mid-wait: counter must restart.
    for (int i = 0; i < 2; i++)
      tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 9'h030, 32'h11, 1'b1, 1'b0, 9'h040, 32'h0, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 9'h031, 32'h22, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 9'h032, 32'h33, 1'b1, 1'b0, 9'h040, 32'h0, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 9'h032, 32'h33, 1'b1, 1'b0, 9'h040, 32'h0, 1'b0, 1'b1));
    // Reset mid-wait also restarts the counter.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 9'h033, 32'h44, 1'b1, 1'b1, 9'h041, 32'h55, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b1, 1'b1, 9'h033, 32'h44, 1'b1, 1'b1, 9'h041, 32'h55, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 9'h034, 32'h66, 1'b1, 1'b1, 9'h042, 32'h77, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 9'h034, 32'h66, 1'b1, 1'b1, 9'h042, 32'h77, 1'b0, 1'b1));
    // Only m1 requests: write, read it back, read another.
    tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b1, 9'h050, 32'h12345678, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h050, 32'h0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h002, 32'h0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Continuous contention: m0,m0,m0,m0,m1 repeating, reads from both ports.
    for (int i = 0; i < 15; i++) begin
      v = mkv(1'b0, 1'b1, 1'b0, 9'(9'h060 + i), 32'h0, 1'b1, 1'b0, 9'h005, 32'h0,
              (i % 5) != 4, (i % 5) == 4);
      apply(v, $sformatf("starve%0d", i));
    end
    apply(mkv(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0), "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
